// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for inst_fetch_queue: push side (in_*), pop side (out_*) and occupancy.
interface inst_fetch_queue_if #(
   parameter int unsigned CNT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_pc;
   logic [31:0]      in_instr;
   logic             in_adef;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [31:0]      out_instr;
   logic             out_adef;
   logic [CNT_W-1:0] count;

   modport master (
      output in_valid, in_pc, in_instr, in_adef, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_adef, count
   );

   modport slave (
      input  in_valid, in_pc, in_instr, in_adef, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_adef, count
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue between fetch and decode, with flush and synchronous active-low reset.
// Optional macro IFQ_BYPASS_EN: an empty queue forwards the incoming instruction in the same cycle.
module inst_fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 3
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                flush,
   inst_fetch_queue_if.slave   bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adef;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_FULL
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   entry_t           r_mem [DEPTH];
   entry_t           w_in_entry;
   entry_t           w_head;
   logic             w_in_ready;
   logic             w_push;
   logic             w_pop;

   assign w_in_entry.pc    = bus.in_pc;
   assign w_in_entry.instr = bus.in_instr;
   assign w_in_entry.adef  = bus.in_adef;
   assign w_head           = r_mem[r_rd_ptr];

   // No push-through when full; nothing is accepted in a flush cycle.
   assign w_in_ready = (r_state != ST_FULL) && !flush;
   assign w_pop      = (r_state != ST_EMPTY) && bus.out_ready && !flush;

`ifdef IFQ_BYPASS_EN
   logic w_bypass;

   assign w_bypass      = (r_state == ST_EMPTY) && bus.in_valid && !flush;
   // A bypassed instruction consumed the same cycle is never stored.
   assign w_push        = bus.in_valid && w_in_ready && !(w_bypass && bus.out_ready);
   assign bus.out_valid = (r_state != ST_EMPTY) || w_bypass;
   assign bus.out_pc    = w_bypass ? w_in_entry.pc    : w_head.pc;
   assign bus.out_instr = w_bypass ? w_in_entry.instr : w_head.instr;
   assign bus.out_adef  = w_bypass ? w_in_entry.adef  : w_head.adef;
`else
   assign w_push        = bus.in_valid && w_in_ready;
   assign bus.out_valid = (r_state != ST_EMPTY);
   assign bus.out_pc    = w_head.pc;
   assign bus.out_instr = w_head.instr;
   assign bus.out_adef  = w_head.adef;
`endif

   assign bus.in_ready = w_in_ready;
   assign bus.count    = r_count;

   // Occupancy next-state: flush clears, push/pop adjust count, state follows count.
   always_comb begin
      w_count_nxt = r_count;
      w_state_nxt = r_state;
      if (flush) begin
         w_count_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
      if (w_count_nxt == '0) begin
         w_state_nxt = ST_EMPTY;
      end else if (w_count_nxt == CNT_W'(DEPTH)) begin
         w_state_nxt = ST_FULL;
      end else begin
         w_state_nxt = ST_PARTIAL;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= ST_EMPTY;
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (rstn && w_push) begin
         r_mem[r_wr_ptr] <= w_in_entry;
      end
   end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter CNT_W, default 3: width of `count`; must equal log2(DEPTH)+1.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rstn  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 flush  in  1  discards all entries; driven by branch-taken, exception or ertn redirect.
REQ-006 in_valid  in  1  fetch stage presents an instruction.
REQ-007 in_ready  out  1  queue accepts the presented instruction this cycle.
REQ-008 in_pc  in  32  PC of the fetched instruction.
REQ-009 in_instr  in  32  fetched instruction word.
REQ-010 in_adef  in  1  fetch address-error flag for this PC.
REQ-011 out_valid  out  1  head entry is available to decode.
REQ-012 out_ready  in  1  decode consumes the head entry this cycle.
REQ-013 out_pc  out  32  head PC; feeds the decode controller pcF input.
REQ-014 out_instr  out  32  head instruction word; feeds the decode controller INSTR input.
REQ-015 out_adef  out  1  head fetch-error flag.
REQ-016 count  out  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH 65-bit entries {pc, instr, adef}, with rd_ptr and wr_ptr each log2(DEPTH) bits wide.
- Both pointers wrap from DEPTH-1 to 0.
REQ-018 Occupancy state SHALL be one of:
- EMPTY: count==0
- PARTIAL: 0<count<DEPTH
- FULL: count==DEPTH
REQ-019 in_ready SHALL equal (count<DEPTH) and not flush; there is no same-cycle push-through when FULL.
REQ-020 A push SHALL occur when in_valid and in_ready are both high; it writes mem[wr_ptr] and increments wr_ptr.
REQ-021 A pop SHALL occur when out_valid and out_ready are both high; it increments rd_ptr.
REQ-022 A simultaneous push and pop SHALL leave count unchanged.
- In PARTIAL, both pointers advance.
REQ-023 out_valid SHALL equal (count!=0).
- out_pc, out_instr and out_adef come combinationally from mem[rd_ptr].
- Their values are don't-care when out_valid is low.
REQ-024 Latency: an entry pushed in cycle N SHALL be visible on the outputs no earlier than cycle N+1, unless IFQ_BYPASS_EN is defined (REQ-031).
REQ-025 out_ready while EMPTY SHALL have no effect: count stays 0 and rd_ptr is unchanged.
REQ-026 in_valid while FULL SHALL not be accepted; the fetch stage holds its inputs stable until in_ready is high.
REQ-027 Flush SHALL take priority over push and pop.
- On a flush edge: count<=0, rd_ptr<=0, wr_ptr<=0.
- An input presented in the flush cycle is dropped.
- Any pop in the flush cycle is void.
REQ-028 The cycle after flush SHALL start in EMPTY with in_ready=1.
REQ-029 Entry order SHALL be strictly FIFO; no entry is duplicated or lost except by flush or reset.

Reset
REQ-030 When rstn==0 at a clock edge: count<=0, rd_ptr<=0, wr_ptr<=0.
- Outputs in the following cycle: out_valid=0, in_ready=1, count=0.
- Memory contents are not reset.
- Reset mid-operation discards all entries exactly as flush does.
- Reset dominates flush.

Configuration
REQ-031 Macro IFQ_BYPASS_EN, when defined, SHALL enable bypass when the queue is EMPTY and in_valid==1 and flush==0.
- out_valid=1 and the outputs mirror in_pc, in_instr and in_adef combinationally.
- If out_ready==1 in that cycle, the instruction is consumed and not written; count stays 0.
- If out_ready==0, the instruction is written normally, becoming visible on the outputs as the stored head from the next cycle.
REQ-032 When IFQ_BYPASS_EN is not defined, out_valid SHALL strictly equal (count!=0), and no combinational path SHALL exist from the in_* ports to the out_* ports.

Verification
REQ-033 Reset, then push pc=0x1C000000 instr=0x02800C21 with out_ready=0 -> next cycle:
- out_valid=1, out_pc=0x1C000000, out_instr=0x02800C21, count=1.
REQ-034 Push 4 entries (pc 0x1C000000..0x1C00000C) with out_ready=0, DEPTH=4:
- count=4 and in_ready=0.
- A fifth in_valid is not accepted; out_pc stays 0x1C000000.
REQ-035 From count=2, assert in_valid and out_ready together for 3 cycles:
- count stays 2.
- Outputs step through pc order with no gap, including wrap of both pointers past index 3.
REQ-036 From count=3, assert flush together with in_valid and out_ready:
- next cycle count=0, out_valid=0, in_ready=1.
- The flushed-cycle input never appears at the output.
REQ-037 From count=2, drive rstn=0 for one cycle together with flush=0 -> next cycle count=0, out_valid=0.
- Subsequent push of pc=0x1C000040 is the first output.
REQ-038 With IFQ_BYPASS_EN, queue EMPTY, in_valid=1 with pc=0x1C000100 and in_adef=1, out_ready=1:
- The same cycle shows out_valid=1, out_pc=0x1C000100, out_adef=1.
- Next cycle count=0.
